sync_fifo_flagged: RTL and testbench

//   Parametrised single-clock FIFO with valid/ready handshakes on both sides.

---
 rtl/sync_fifo_flagged.sv | 132 +++++++++++++
 tb/tb_sync_fifo_flagged.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock first-word-fall-through FIFO.
// Valid/ready handshakes on both sides, occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush, and sticky
// overflow/underflow error flags. Any DEPTH >= 2 is supported; pointers
// wrap explicitly at DEPTH-1, so non-power-of-two depths work.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] AF_THRESH = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_THRESH = CNT_W'(AE_LEVEL);

  // Storage; deliberately not reset, the pointers define what is valid.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_W-1:0] r_ptr_q, r_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full_w;
  logic empty_w;
  logic push_w;
  logic pop_w;

  // Explicit wrap so that a non-power-of-two depth never indexes past the end.
  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    ptrInc = (p == PTR_LAST) ? '0 : (p + PTR_ONE);
  endfunction

  // Status derived purely from the registered count.
  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // A transfer happens only when the handshake completes on the relevant side.
  assign push_w = in_valid & ~full_w;
  assign pop_w  = out_ready & ~empty_w;

  // Next pointer/count state; flush discards contents and any same-cycle transfer.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (flush) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (push_w) begin
        w_ptr_d = ptrInc(w_ptr_q);
      end
      if (pop_w) begin
        r_ptr_d = ptrInc(r_ptr_q);
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky error flags: any attempt against a full/empty FIFO is remembered until reset.
  always_comb begin
    overflow_d  = overflow_q  | (in_valid  & full_w);
    underflow_d = underflow_q | (out_ready & empty_w);
  end

  // Control state registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Memory write on an accepted push; suppressed while reset or flush discard the transfer.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_w) begin
      mem_q[w_ptr_q] <= in_data;
    end
  end

  assign in_ready     = ~full_w;
  assign out_valid    = ~empty_w;
  assign out_data     = mem_q[r_ptr_q];
  assign count        = count_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_THRESH);
  assign almost_empty = (count_q <= AE_THRESH);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb_sync_fifo_flagged: drives one stimulus stream into two FIFOs (DEPTH=8
// and DEPTH=5) and compares both against queue-based models every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_sync_fifo_flagged;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       inValid;
  logic [7:0] inData;
  logic       outReady;

  logic       inReadyA, outValidA, fullA, emptyA, afA, aeA, ovfA, udfA;
  logic [7:0] outDataA;
  logic [3:0] countA;

  logic       inReadyB, outValidB, fullB, emptyB, afB, aeB, ovfB, udfB;
  logic [7:0] outDataB;
  logic [2:0] countB;

  int checkCount = 0;
  int passCount  = 0;
  bit cmpEn      = 0;

  // Reference models: plain queues and sticky bits.
  logic [7:0] qA[$];
  logic [7:0] qB[$];
  bit mOvfA, mUdfA, mOvfB, mUdfB;

  localparam int DEPTH_A = 8, AF_A = 6, AE_A = 1;
  localparam int DEPTH_B = 5, AF_B = 4, AE_B = 2;

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(DEPTH_A), .AF_LEVEL(AF_A), .AE_LEVEL(AE_A)) dutA (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyA), .in_data(inData),
    .out_valid(outValidA), .out_ready(outReady), .out_data(outDataA),
    .count(countA), .full(fullA), .empty(emptyA),
    .almost_full(afA), .almost_empty(aeA),
    .overflow(ovfA), .underflow(udfA)
  );

  sync_fifo_flagged #(.DATA_WIDTH(8), .DEPTH(DEPTH_B), .AF_LEVEL(AF_B), .AE_LEVEL(AE_B)) dutB (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(inValid), .in_ready(inReadyB), .in_data(inData),
    .out_valid(outValidB), .out_ready(outReady), .out_data(outDataB),
    .count(countB), .full(fullB), .empty(emptyB),
    .almost_full(afB), .almost_empty(aeB),
    .overflow(ovfB), .underflow(udfB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Model update on each rising edge from the inputs and the model's own occupancy.
  always @(posedge clk) begin
    bit pushA, popA, pushB, popB;
    if (rst) begin
      qA.delete();
      qB.delete();
      mOvfA = 0; mUdfA = 0; mOvfB = 0; mUdfB = 0;
    end else begin
      if (inValid && qA.size() == DEPTH_A) mOvfA = 1;
      if (outReady && qA.size() == 0) mUdfA = 1;
      if (inValid && qB.size() == DEPTH_B) mOvfB = 1;
      if (outReady && qB.size() == 0) mUdfB = 1;
      if (flush) begin
        qA.delete();
        qB.delete();
      end else begin
        pushA = inValid && (qA.size() < DEPTH_A);
        popA  = outReady && (qA.size() > 0);
        pushB = inValid && (qB.size() < DEPTH_B);
        popB  = outReady && (qB.size() > 0);
        if (popA) void'(qA.pop_front());
        if (pushA) qA.push_back(inData);
        if (popB) void'(qB.pop_front());
        if (pushB) qB.push_back(inData);
      end
    end
  end

  // Every-cycle comparison of both DUTs against their models.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("A.count",        32'(countA),    32'(qA.size()));
      checkOutput("A.full",         32'(fullA),     32'(qA.size() == DEPTH_A));
      checkOutput("A.empty",        32'(emptyA),    32'(qA.size() == 0));
      checkOutput("A.in_ready",     32'(inReadyA),  32'(qA.size() != DEPTH_A));
      checkOutput("A.out_valid",    32'(outValidA), 32'(qA.size() != 0));
      checkOutput("A.almost_full",  32'(afA),       32'(qA.size() >= AF_A));
      checkOutput("A.almost_empty", 32'(aeA),       32'(qA.size() <= AE_A));
      checkOutput("A.overflow",     32'(ovfA),      32'(mOvfA));
      checkOutput("A.underflow",    32'(udfA),      32'(mUdfA));
      if (qA.size() > 0) checkOutput("A.out_data", 32'(outDataA), 32'(qA[0]));
      checkOutput("B.count",        32'(countB),    32'(qB.size()));
      checkOutput("B.full",         32'(fullB),     32'(qB.size() == DEPTH_B));
      checkOutput("B.empty",        32'(emptyB),    32'(qB.size() == 0));
      checkOutput("B.in_ready",     32'(inReadyB),  32'(qB.size() != DEPTH_B));
      checkOutput("B.out_valid",    32'(outValidB), 32'(qB.size() != 0));
      checkOutput("B.almost_full",  32'(afB),       32'(qB.size() >= AF_B));
      checkOutput("B.almost_empty", 32'(aeB),       32'(qB.size() <= AE_B));
      checkOutput("B.overflow",     32'(ovfB),      32'(mOvfB));
      checkOutput("B.underflow",    32'(udfB),      32'(mUdfB));
      if (qB.size() > 0) checkOutput("B.out_data", 32'(outDataB), 32'(qB[0]));
    end
  end

  // Drive one cycle of inputs at the falling edge, return 1ns after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r,
                               input logic f, input logic rs);
    @(negedge clk);
    inValid  = v;
    inData   = d;
    outReady = r;
    flush    = f;
    rst      = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; inData = 8'h00; outReady = 1'b0;

    // Reset state
    applyStimulus(0, 8'h00, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    cmpEn = 1;
    checkOutput("rst.countA", 32'(countA), 32'd0);
    checkOutput("rst.emptyA", 32'(emptyA), 32'd1);
    checkOutput("rst.inReadyA", 32'(inReadyA), 32'd1);
    checkOutput("rst.outValidA", 32'(outValidA), 32'd0);
    checkOutput("rst.aeA", 32'(aeA), 32'd1);
    checkOutput("rst.afA", 32'(afA), 32'd0);

    // Fill with 0x01..0x08, consumer stalled
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 8'(i), 0, 0, 0);
      checkOutput("fill.countA", 32'(countA), 32'(i));
      checkOutput("fill.afA", 32'(afA), (i >= 6) ? 32'd1 : 32'd0);
      checkOutput("fill.headA", 32'(outDataA), 32'h01);
    end
    checkOutput("fill.fullA", 32'(fullA), 32'd1);
    checkOutput("fill.countB", 32'(countB), 32'd5);
    checkOutput("fill.fullB", 32'(fullB), 32'd1);
    checkOutput("fill.ovfB", 32'(ovfB), 32'd1);

    // Push against a full FIFO
    applyStimulus(1, 8'hFF, 0, 0, 0);
    checkOutput("ovf.countA", 32'(countA), 32'd8);
    checkOutput("ovf.inReadyA", 32'(inReadyA), 32'd0);
    checkOutput("ovf.ovfA", 32'(ovfA), 32'd1);

    // Drain: head must walk 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      checkOutput("drain.headA", 32'(outDataA), 32'(i));
      applyStimulus(0, 8'h00, 1, 0, 0);
    end
    checkOutput("drain.emptyA", 32'(emptyA), 32'd1);
    checkOutput("drain.udfA", 32'(udfA), 32'd0);

    // Pop and push together while empty
    applyStimulus(1, 8'hA5, 1, 0, 0);
    checkOutput("emptyPush.udfA", 32'(udfA), 32'd1);
    checkOutput("emptyPush.countA", 32'(countA), 32'd1);
    checkOutput("emptyPush.outValidA", 32'(outValidA), 32'd1);
    checkOutput("emptyPush.headA", 32'(outDataA), 32'hA5);

    // Build count=3, then stream push+pop for 20 cycles across the wrap
    applyStimulus(1, 8'h10, 0, 0, 0);
    applyStimulus(1, 8'h11, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'(8'h20 + i), 1, 0, 0);
      checkOutput("stream.countA", 32'(countA), 32'd3);
    end
    checkOutput("stream.headA", 32'(outDataA), 32'h31);

    // Empty out, fill the 5-deep FIFO exactly, then mixed bursts
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h50 + i), 0, 0, 0);
    checkOutput("burst.countB", 32'(countB), 32'd5);
    checkOutput("burst.fullB", 32'(fullB), 32'd1);
    checkOutput("burst.headB", 32'(outDataB), 32'h50);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(((k % 7) < 4) ? 1'b1 : 1'b0, 8'(8'h60 + k), ((k % 5) >= 2) ? 1'b1 : 1'b0, 0, 0);
    end
    for (int i = 0; i < 9; i++) applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("burst.emptyB", 32'(emptyB), 32'd1);

    // count=4 with overflow set, then flush with a competing push
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'hC0 + i), 0, 0, 0);
    checkOutput("flush.preCountA", 32'(countA), 32'd4);
    applyStimulus(1, 8'h99, 1, 1, 0);
    checkOutput("flush.countA", 32'(countA), 32'd0);
    checkOutput("flush.emptyA", 32'(emptyA), 32'd1);
    checkOutput("flush.ovfA", 32'(ovfA), 32'd1);
    checkOutput("flush.udfA", 32'(udfA), 32'd1);

    // Reset clears the sticky flags
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("rst2.ovfA", 32'(ovfA), 32'd0);
    checkOutput("rst2.udfA", 32'(udfA), 32'd0);
    checkOutput("rst2.ovfB", 32'(ovfB), 32'd0);
    applyStimulus(0, 8'h00, 0, 0, 0);
    applyStimulus(0, 8'h00, 0, 0, 0);

    cmpEn = 0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
